instruction_fetcher: RTL
========================

# instruction_fetcher

Refill engine and front-end port for the direct-mapped instruction cache. It accepts a fetch PC from the IF stage and probes the cache combinationally. On a hit it returns the word; on a miss it wins the memory arbiter, reads the four bytes little-endian over the byte-wide RAM port, writes the assembled word into the cache, and returns it. It is the sole driver of the cache's write port (`ic_we`/`ic_data`) and sits between the IF stage, the instruction cache and the memory arbiter.

## Interface
- `MEM_LAT`, default 1: cycles from `mem_a` driven to matching `mem_din` valid; legal range 1..3.
- `clk_in` input 1: clock, posedge.
- `rst_n_in` input 1: reset, asynchronous, active-low.
- `rdy_in` input 1: global enable; when low, every register holds.
- `req_valid` input 1: IF presents a fetch.
- `req_pc` input 32: fetch address; bits [1:0] are 0.
- `req_ready` output 1: fetch accepted this cycle (`req_valid && req_ready`).
- `flush` input 1: pipeline redirect; cancels any pending response.
- `resp_valid` output 1: one-cycle pulse, instruction returned.
- `resp_inst` output 32: instruction word.
- `resp_pc` output 32: PC of `resp_inst`.
- `ic_addr` output 32: cache probe/write address.
- `ic_hit` input 1: cache hit for `ic_addr` (combinational).
- `ic_res` input 32: cache data for `ic_addr` (combinational).
- `ic_we` output 1: cache write enable.
- `ic_data` output 32: cache write data.
- `mem_req` output 1: arbiter request.
- `mem_gnt` input 1: arbiter grant; held while `mem_req` is high.
- `mem_a` output 32: RAM byte address.
- `mem_din` input 8: RAM read byte.

## Operation
- FSM states:
  - IDLE: `req_ready` = `!flush`.
  - REQ: waiting for grant.
  - FILL: issuing addresses and collecting bytes.
  - WRITE: single cycle.
- `ic_addr` = `req_pc` in IDLE; otherwise the latched PC `cur_pc`.
- IDLE, accept, `ic_hit`=1: register `resp_inst`=`ic_res` and `resp_pc`=`req_pc`; `resp_valid`=1 next cycle; stay in IDLE. Back-to-back hits run at one per cycle.
- IDLE, accept, `ic_hit`=0: latch `cur_pc`, clear `cancel`, go to REQ.
- REQ: `mem_req`=1, `mem_a`=`cur_pc`. The cycle with `mem_gnt`=1 issues byte 0.
  - Go to FILL with issue count `iss`=1 and receive count `rcv`=0.
- FILL:
  - While `iss`<4: `mem_a`=`cur_pc`+`iss` and `iss` increments.
  - `mem_req` stays 1 through the cycle issuing byte 3, then drops.
  - A `MEM_LAT`-deep valid shift register tags returning bytes. Byte `rcv` goes to `buf[8*rcv+:8]`.
  - When `rcv` reaches 4, go to WRITE.
- WRITE: `ic_we`=1, `ic_addr`=`cur_pc`, `ic_data`=`buf`. `resp_valid`=`!cancel && !flush`. Return to IDLE.
- `req_ready`=0 outside IDLE.
- `flush`:
  - Clears `resp_valid` the next cycle.
  - In REQ or FILL it sets `cancel`. The refill still completes and writes the cache, but no response is produced.
  - In IDLE with `req_valid` in the same cycle: the request is not accepted.
- `rdy_in`=0: FSM, counters and outputs hold. `ic_we` is forced 0 for that cycle, and WRITE retires on the next `rdy_in`=1 cycle.
- Address arithmetic is 32-bit wrapping. 0xFFFFFFFC+3 = 0xFFFFFFFF, with no carry into the next line.

## Timing
- Reset values: IDLE, `resp_valid`=0, `resp_inst`=0, `resp_pc`=0, `ic_we`=0, `ic_data`=0, `mem_req`=0, `mem_a`=0, `cancel`=0, counters=0.
- Hit: accept in cycle N, `resp_valid` in N+1.
- Miss with grant in cycle G:
  - Bytes are issued G..G+3 and received G+MEM_LAT..G+3+MEM_LAT.
  - WRITE and response fall in G+4+MEM_LAT (G+5 at the default).
  - Next accept no earlier than G+5+MEM_LAT.
- Reset mid-fill: immediate return to IDLE with `mem_req`=0. In-flight RAM bytes are ignored and the cache is not written.
- `mem_gnt` while not in REQ: ignored.

## Structure
- The shared const header holds `ICACHE_SIZE_BIT`, FSM state encodings, and `MEM_LAT_MAX`=3.
- One natural sub-module: `byte_assembler`, the `MEM_LAT` valid pipe plus the 4-byte shift/merge with a done flag. The FSM stays in `instruction_fetcher`.

## Test plan
- Miss then hit, default `MEM_LAT`=1:
  - Setup: RAM 0x100..0x103 = 13,05,A0,00; fetch 0x100, grant immediately.
  - Miss: `mem_a` 0x100..0x103 in G..G+3. G+5 has `ic_we`=1, `ic_data`=0x00A00513, `resp_valid`=1, `resp_pc`=0x100.
  - Refetch 0x100 → `resp_valid` next cycle, with no `mem_req`.
- Grant delayed 6 cycles: `mem_req` is held high and `mem_a`=0x200 constant throughout. The response lands exactly 5 cycles after grant.
- Flush during FILL (after byte 1): cache is still written (`ic_we`=1, correct word), `resp_valid` never asserts, and `req_ready`=1 the following cycle.
- `rdy_in` low for 3 cycles mid-FILL: `mem_a` and counters freeze. The assembled word is still correct, and the response is delayed by exactly 3 cycles.
- `rst_n_in` pulsed low mid-FILL: asynchronous clear. `mem_req`=0 and `resp_valid`=0 immediately, and `ic_we` is never asserted for that PC.
- `MEM_LAT`=3, fetch 0xFFFFFFFC: addresses 0xFFFFFFFC..0xFFFFFFFF, and the response arrives at G+7.

Source files
------------

// File: rtl/instruction_fetcher_pkg.sv
// Shared constants for the instruction fetcher: cache geometry, FSM encodings,
// RAM latency bound and the wrapping byte-address helper.
package instruction_fetcher_pkg;

  localparam int unsigned ICACHE_SIZE_BIT = 8;
  localparam int unsigned MEM_LAT_MAX     = 3;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t StIdle  = 2'd0;
  localparam fetch_state_t StReq   = 2'd1;
  localparam fetch_state_t StFill  = 2'd2;
  localparam fetch_state_t StWrite = 2'd3;

  // 32-bit wrapping add; a line at the top of memory never carries into bit 32.
  function automatic logic [31:0] byte_addr(input logic [31:0] base, input logic [2:0] off);
    return base + {29'd0, off};
  endfunction

endpackage

// File: rtl/instruction_fetcher_byte_assembler.sv
// Tags returning RAM bytes with a MemLat-deep valid pipe and merges them
// little-endian into one 32-bit word.
module instruction_fetcher_byte_assembler
  import instruction_fetcher_pkg::*;
#(
  parameter int unsigned MemLat = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        issue_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        done_o
);

  localparam int unsigned Lat = (MemLat < 1) ? 1 :
                                (MemLat > MEM_LAT_MAX) ? MEM_LAT_MAX : MemLat;

  logic [Lat-1:0] vld_q, vld_d;
  logic [2:0]     rcv_q, rcv_d;
  logic [31:0]    word_q, word_d;
  logic           arrive;

  assign arrive = vld_q[Lat-1];

  // The RAM answers at a fixed latency, so this path keeps running even while
  // the fetch FSM is stalled; only new issues are gated upstream.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue_i;
    for (int i = 1; i < Lat; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    rcv_d  = rcv_q;
    word_d = word_q;
    if (start_i) begin
      rcv_d  = 3'd0;
      word_d = 32'd0;
    end else if (arrive && (rcv_q < 3'd4)) begin
      word_d[{rcv_q[1:0], 3'b000} +: 8] = byte_i;
      rcv_d = rcv_q + 3'd1;
    end
  end

  // Done is raised in the cycle the last byte lands so WRITE follows directly.
  assign done_o = (rcv_q == 3'd4) || (arrive && (rcv_q == 3'd3) && !start_i);
  assign word_o = word_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      rcv_q  <= 3'd0;
      word_q <= 32'd0;
    end else begin
      vld_q  <= vld_d;
      rcv_q  <= rcv_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/instruction_fetcher.sv
// Front-end port and refill engine for the direct-mapped instruction cache:
// hits answer next cycle, misses fetch four RAM bytes and write the cache.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_inst,
  output logic [31:0] resp_pc,
  output logic [31:0] ic_addr,
  input  logic        ic_hit,
  input  logic [31:0] ic_res,
  output logic        ic_we,
  output logic [31:0] ic_data,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_a,
  input  logic [7:0]  mem_din
);

  fetch_state_t state_q, state_d;
  logic [31:0]  cur_pc_q, cur_pc_d;
  logic [2:0]   iss_q, iss_d;
  logic         cancel_q, cancel_d;
  logic         resp_valid_q, resp_valid_d;
  logic [31:0]  resp_inst_q, resp_inst_d;
  logic [31:0]  resp_pc_q, resp_pc_d;

  logic        accept;
  logic        fill_issuing;
  logic        in_write;
  logic        start;
  logic        issue;
  logic        asm_done;
  logic [31:0] asm_word;

  assign req_ready    = (state_q == StIdle) && !flush && rdy_in;
  assign accept       = req_valid && req_ready;
  assign fill_issuing = (state_q == StFill) && (iss_q < 3'd4);
  assign in_write     = (state_q == StWrite);
  assign start        = rdy_in && (state_q == StReq) && mem_gnt;
  assign issue        = start || (rdy_in && fill_issuing);

  instruction_fetcher_byte_assembler #(
    .MemLat (MEM_LAT)
  ) u_byte_assembler (
    .clk_i   (clk_in),
    .rst_ni  (rst_n_in),
    .start_i (start),
    .issue_i (issue),
    .byte_i  (mem_din),
    .word_o  (asm_word),
    .done_o  (asm_done)
  );

  always_comb begin
    state_d      = state_q;
    cur_pc_d     = cur_pc_q;
    iss_d        = iss_q;
    cancel_d     = cancel_q;
    resp_valid_d = 1'b0;
    resp_inst_d  = resp_inst_q;
    resp_pc_d    = resp_pc_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (ic_hit) begin
            resp_valid_d = 1'b1;
            resp_inst_d  = ic_res;
            resp_pc_d    = req_pc;
          end else begin
            cur_pc_d = req_pc;
            cancel_d = 1'b0;
            state_d  = StReq;
          end
        end
      end
      StReq: begin
        if (flush) cancel_d = 1'b1;
        if (mem_gnt) begin
          iss_d   = 3'd1;
          state_d = StFill;
        end
      end
      StFill: begin
        if (flush) cancel_d = 1'b1;
        if (fill_issuing) iss_d = iss_q + 3'd1;
        if (asm_done) state_d = StWrite;
      end
      StWrite: begin
        iss_d   = 3'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_a = 32'd0;
    if (state_q == StReq) begin
      mem_a = cur_pc_q;
    end else if (fill_issuing) begin
      mem_a = byte_addr(cur_pc_q, iss_q);
    end
  end

  assign mem_req    = (state_q == StReq) || fill_issuing;
  assign ic_addr    = (state_q == StIdle) ? req_pc : cur_pc_q;
  // A stalled WRITE must not commit; it retires on the next enabled cycle.
  assign ic_we      = in_write && rdy_in;
  assign ic_data    = in_write ? asm_word : 32'd0;
  assign resp_valid = resp_valid_q || (in_write && rdy_in && !cancel_q && !flush);
  assign resp_inst  = in_write ? asm_word : resp_inst_q;
  assign resp_pc    = in_write ? cur_pc_q : resp_pc_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= StIdle;
      cur_pc_q     <= 32'd0;
      iss_q        <= 3'd0;
      cancel_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_inst_q  <= 32'd0;
      resp_pc_q    <= 32'd0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      cur_pc_q     <= cur_pc_d;
      iss_q        <= iss_d;
      cancel_q     <= cancel_d;
      resp_valid_q <= resp_valid_d;
      resp_inst_q  <= resp_inst_d;
      resp_pc_q    <= resp_pc_d;
    end
  end

endmodule
